// File: rtl/simon_key_rev_if.sv
`default_nettype none
// ============================================================================
// Module   : simon_key_rev_if
// Brief    : Round-key stream between the inverse key schedule and its consumer.
// Revision : 1.0
// ============================================================================
interface simon_key_rev_if;
    logic        rk_valid;
    logic        rk_ready;
    logic [15:0] rk_data;
    logic [4:0]  rk_idx;

    modport master (
        output rk_valid,
        output rk_data,
        output rk_idx,
        input  rk_ready
    );

    modport slave (
        input  rk_valid,
        input  rk_data,
        input  rk_idx,
        output rk_ready
    );
endinterface
`default_nettype wire

// File: rtl/simon_key_rev.sv
`default_nettype none
// ============================================================================
// Module   : simon_key_rev
// Brief    : Simon32/64 inverse key schedule, emits k[N-1]..k[0] one per beat.
// Revision : 1.0
// ============================================================================
module simon_key_rev #(
    parameter int          NUM_ROUNDS = 32,
    parameter logic [15:0] C_CONST    = 16'hfffc,
    parameter logic [61:0] Z_SEQ      = 62'b01100111000011010100100010111110110011100001101010010001011111
) (
    input  wire                clk,
    input  wire                rst,
    input  wire                start,
    input  wire         [63:0] last_keys,
    simon_key_rev_if.master    rk_bus,
    output logic               busy,
    output logic               done,
    output logic        [63:0] master_key
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_fin  = 2'd2;

    localparam logic [4:0] c_idx_last = 5'(NUM_ROUNDS - 1);
    localparam logic [4:0] c_idx_n2   = 5'(NUM_ROUNDS - 2);
    localparam logic [4:0] c_idx_n3   = 5'(NUM_ROUNDS - 3);
    localparam logic [4:0] c_idx_n4   = 5'(NUM_ROUNDS - 4);

    function automatic logic [15:0] ror1(input logic [15:0] x);
        return {x[0], x[15:1]};
    endfunction

    function automatic logic [15:0] ror3(input logic [15:0] x);
        return {x[2:0], x[15:3]};
    endfunction

    logic [1:0]  r_state;
    // Window of the four lowest-indexed known keys: a=k[m], b=k[m+1], c=k[m+2], d=k[m+3]
    logic [15:0] r_win_a;
    logic [15:0] r_win_b;
    logic [15:0] r_win_c;
    logic [15:0] r_win_d;
    logic        r_rk_valid;
    logic [15:0] r_rk_data;
    logic [4:0]  r_rk_idx;
    logic        r_busy;
    logic        r_done;
    logic [63:0] r_master_key;

    logic [4:0]  w_next_idx;
    logic [15:0] w_t;
    logic [15:0] w_calc;
    logic [15:0] w_next_key;
    logic        w_shift;
    logic        w_hs;

    assign w_hs = r_rk_valid & rk_bus.rk_ready;

    always_comb begin
        w_next_idx = r_rk_idx - 5'd1;
        w_t        = ror3(r_win_c) ^ r_win_a;
        w_calc     = r_win_d ^ w_t ^ ror1(w_t) ^ C_CONST ^ {15'b0, Z_SEQ[w_next_idx]};
        w_next_key = w_calc;
        w_shift    = 1'b0;
        // The three keys below k[N-1] are already in the loaded window
        if (w_next_idx == c_idx_n2) begin
            w_next_key = r_win_c;
        end else if (w_next_idx == c_idx_n3) begin
            w_next_key = r_win_b;
        end else if (w_next_idx == c_idx_n4) begin
            w_next_key = r_win_a;
        end else begin
            w_shift = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_win_a      <= 16'd0;
            r_win_b      <= 16'd0;
            r_win_c      <= 16'd0;
            r_win_d      <= 16'd0;
            r_rk_valid   <= 1'b0;
            r_rk_data    <= 16'd0;
            r_rk_idx     <= 5'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_master_key <= 64'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_win_a    <= last_keys[63:48];
                        r_win_b    <= last_keys[47:32];
                        r_win_c    <= last_keys[31:16];
                        r_win_d    <= last_keys[15:0];
                        r_rk_valid <= 1'b1;
                        r_rk_data  <= last_keys[15:0];
                        r_rk_idx   <= c_idx_last;
                        r_busy     <= 1'b1;
                        r_state    <= c_st_run;
                    end
                end
                c_st_run: begin
                    if (w_hs) begin
                        if (r_rk_idx == 5'd0) begin
                            // Window now holds k[0..3] after the final shift
                            r_master_key <= {r_win_a, r_win_b, r_win_c, r_win_d};
                            r_rk_valid   <= 1'b0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= c_st_fin;
                        end else begin
                            r_rk_idx  <= w_next_idx;
                            r_rk_data <= w_next_key;
                            if (w_shift) begin
                                r_win_a <= w_calc;
                                r_win_b <= r_win_a;
                                r_win_c <= r_win_b;
                                r_win_d <= r_win_c;
                            end
                        end
                    end
                end
                c_st_fin: begin
                    r_done  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign rk_bus.rk_valid = r_rk_valid;
    assign rk_bus.rk_data  = r_rk_data;
    assign rk_bus.rk_idx   = r_rk_idx;
    assign busy            = r_busy;
    assign done            = r_done;
    assign master_key      = r_master_key;

endmodule
`default_nettype wire

// File: tb/tb_simon_key_rev.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_key_rev
// Brief    : Directed self-checking bench for simon_key_rev (N=32 and N=5).
// Revision : 1.0
// ============================================================================
module tb_simon_key_rev;

    localparam logic [61:0] c_z0 = 62'b01100111000011010100100010111110110011100001101010010001011111;
    localparam logic [63:0] c_key_ref = 64'h1918_1110_0908_0100;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] last_keys;
    logic        busy;
    logic        done;
    logic [63:0] master_key;

    logic        start5;
    logic [63:0] last_keys5;
    logic        busy5;
    logic        done5;
    logic [63:0] master_key5;

    int n_checks;
    int n_errors;

    logic [15:0] exp_k [0:31];

    simon_key_rev_if bus ();
    simon_key_rev_if bus5 ();

    simon_key_rev dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .last_keys  (last_keys),
        .rk_bus     (bus),
        .busy       (busy),
        .done       (done),
        .master_key (master_key)
    );

    simon_key_rev #(.NUM_ROUNDS(5)) dut5 (
        .clk        (clk),
        .rst        (rst),
        .start      (start5),
        .last_keys  (last_keys5),
        .rk_bus     (bus5),
        .busy       (busy5),
        .done       (done5),
        .master_key (master_key5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Forward Simon32/64 schedule; k[0] is the top word of the key text
    task automatic fwd(input logic [63:0] kt);
        logic [15:0] t;
        exp_k[0] = kt[63:48];
        exp_k[1] = kt[47:32];
        exp_k[2] = kt[31:16];
        exp_k[3] = kt[15:0];
        for (int i = 4; i < 32; i++) begin
            t = {exp_k[i-1][2:0], exp_k[i-1][15:3]} ^ exp_k[i-3];
            exp_k[i] = ~exp_k[i-4] ^ t ^ {t[0], t[15:1]} ^ {15'b0, c_z0[i-4]} ^ 16'd3;
        end
    endtask

    task automatic do_start();
        start     = 1'b1;
        last_keys = {exp_k[28], exp_k[29], exp_k[30], exp_k[31]};
        step();
        start     = 1'b0;
        last_keys = 64'd0;
        chk("start_busy", busy, 1);
    endtask

    task automatic run_main(input int bp, input int inj, input int chk4,
                            input logic [63:0] exp_mk, input string tag);
        int idx;
        int cyc;
        idx = 31;
        cyc = 0;
        while (idx >= 0 && cyc < 300) begin
            bus.rk_ready = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inj != 0) begin
                start     = 1'($urandom_range(0, 1));
                last_keys = {$urandom, $urandom};
            end
            chk({tag, "_valid"}, bus.rk_valid, 1);
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_idx"}, bus.rk_idx, 64'(idx));
            chk({tag, "_data"}, bus.rk_data, exp_k[idx]);
            if (chk4 != 0 && idx == 4) chk({tag, "_k4"}, bus.rk_data, 16'hfffd);
            step();
            cyc++;
            if (bus.rk_ready) idx--;
        end
        start        = 1'b0;
        bus.rk_ready = 1'b0;
        chk({tag, "_complete"}, 64'(idx < 0), 1);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_fin_valid"}, bus.rk_valid, 0);
        chk({tag, "_fin_busy"}, busy, 0);
        chk({tag, "_master"}, master_key, exp_mk);
        step();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_master_hold"}, master_key, exp_mk);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        start        = 1'b0;
        last_keys    = 64'd0;
        start5       = 1'b0;
        last_keys5   = 64'd0;
        bus.rk_ready = 1'b0;
        bus5.rk_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        chk("rst_valid", bus.rk_valid, 0);
        chk("rst_data", bus.rk_data, 0);
        chk("rst_idx", bus.rk_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_master", master_key, 0);
        chk("rst5_valid", bus5.rk_valid, 0);

        // Zero key: k[0..3]=0, k[4]=fffd
        fwd(64'd0);
        do_start();
        run_main(0, 0, 1, 64'd0, "zero");

        // Round trip with the reference key
        fwd(c_key_ref);
        do_start();
        run_main(0, 0, 0, 64'h1918_1110_0908_0100, "trip");

        // Random backpressure
        do_start();
        run_main(1, 0, 0, c_key_ref, "bp");

        // Start pulses with other keys while busy are ignored
        do_start();
        run_main(1, 1, 0, c_key_ref, "inj");

        // Reset mid-run at idx 17, with start also high
        do_start();
        bus.rk_ready = 1'b1;
        for (int i = 0; i < 40 && bus.rk_idx != 5'd17; i++) begin
            chk("pre_rst_data", bus.rk_data, exp_k[bus.rk_idx]);
            step();
        end
        chk("pre_rst_idx", bus.rk_idx, 17);
        rst       = 1'b1;
        start     = 1'b1;
        last_keys = {exp_k[28], exp_k[29], exp_k[30], exp_k[31]};
        step();
        rst          = 1'b0;
        start        = 1'b0;
        bus.rk_ready = 1'b0;
        chk("mrst_valid", bus.rk_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_master", master_key, 0);
        chk("mrst_idx", bus.rk_idx, 0);
        step();
        chk("mrst_idle_valid", bus.rk_valid, 0);
        do_start();
        run_main(0, 0, 0, c_key_ref, "restart");

        // Minimum size instance, N=5
        last_keys5 = {exp_k[1], exp_k[2], exp_k[3], exp_k[4]};
        start5     = 1'b1;
        step();
        start5        = 1'b0;
        bus5.rk_ready = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            chk("n5_valid", bus5.rk_valid, 1);
            chk("n5_idx", bus5.rk_idx, 64'(i));
            chk("n5_data", bus5.rk_data, exp_k[i]);
            step();
        end
        bus5.rk_ready = 1'b0;
        chk("n5_done", done5, 1);
        chk("n5_busy", busy5, 0);
        chk("n5_master", master_key5, 64'h1918_1110_0908_0100);
        step();
        chk("n5_done_pulse", done5, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
